// File: rtl/inst_fetch_queue.sv
// Bundle queue between the IFU and decode: captures whole fetch bundles, issues them
// one instruction per cycle, back-pressures the IFU when full and drops everything on a redirect.
module inst_fetch_queue #(
    parameter int FETCH_WIDTH     = 2,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bundle_valid,
    input  logic [32*FETCH_WIDTH-1:0]     Instruction_Code,
    input  logic [INST_ADDR_WIDTH-1:0]    pc_in,
    input  logic                          flush,
    output logic                          stall,
    output logic                          inst_valid,
    input  logic                          dec_ready,
    output logic [31:0]                   inst_out,
    output logic [INST_ADDR_WIDTH-1:0]    inst_pc,
    output logic [INST_ADDR_WIDTH-1:0]    inst_pc_plus_4,
    output logic [$clog2(QUEUE_DEPTH):0]  occupancy
);

    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int AW     = INST_ADDR_WIDTH;

    logic [32*FETCH_WIDTH-1:0] code_mem [QUEUE_DEPTH];
    logic [AW-1:0]             pc_mem   [QUEUE_DEPTH];
    logic [31:0]               head_slot [FETCH_WIDTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    logic push, issue, pop, last_slot;
    logic [AW-1:0] head_pc;

    // Storage carries no reset; only the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            code_mem[wr_ptr_q] <= Instruction_Code;
            pc_mem[wr_ptr_q]   <= pc_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
            assign head_slot[gi] = code_mem[rd_ptr_q][32*gi +: 32];
        end
    endgenerate

    assign head_pc   = pc_mem[rd_ptr_q];
    assign last_slot = (slot_q == SLOT_W'(FETCH_WIDTH - 1));

    always_comb begin
        stall      = (count_q == CNT_W'(QUEUE_DEPTH));
        inst_valid = (count_q != '0) && !flush;
        push       = bundle_valid && !stall && !flush;
        issue      = inst_valid && dec_ready;
        pop        = issue && last_slot;

        inst_out       = '0;
        inst_pc        = '0;
        if (inst_valid) begin
            inst_out = head_slot[slot_q];
            inst_pc  = head_pc + (AW'(slot_q) << 2);
        end
        inst_pc_plus_4 = inst_pc + AW'(4);
        occupancy      = count_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        slot_d   = slot_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            slot_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (issue) begin
                if (last_slot) begin
                    slot_d   = '0;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            slot_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            slot_q   <= slot_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: an instruction-level queue model checked every
// cycle, plus literal expectations for the basic flow, fill, wrap, flush and reset cases.
module tb_inst_fetch_queue;

    localparam int FW    = 2;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              bundle_valid;
    logic [32*FW-1:0]  Instruction_Code;
    logic [AW-1:0]     pc_in;
    logic              flush;
    logic              stall;
    logic              inst_valid;
    logic              dec_ready;
    logic [31:0]       inst_out;
    logic [AW-1:0]     inst_pc;
    logic [AW-1:0]     inst_pc_plus_4;
    logic [2:0]        occupancy;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] issued_pc[$];

    inst_fetch_queue #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(AW), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bundle_valid(bundle_valid),
        .Instruction_Code(Instruction_Code), .pc_in(pc_in), .flush(flush),
        .stall(stall), .inst_valid(inst_valid), .dec_ready(dec_ready),
        .inst_out(inst_out), .inst_pc(inst_pc), .inst_pc_plus_4(inst_pc_plus_4),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bundles held = instructions still queued, rounded up to whole bundles.
    function automatic int m_occ();
        return (mq.size() + FW - 1) / FW;
    endfunction

    always @(negedge reset) mq.delete();

    always @(posedge clk) begin
        int occ;
        bit v;
        if (reset) begin
            occ = m_occ();
            v   = (mq.size() != 0) && !flush;
            if (flush) begin
                mq.delete();
            end else begin
                if (v && dec_ready) void'(mq.pop_front());
                if (bundle_valid && occ != DEPTH)
                    for (int i = 0; i < FW; i++)
                        mq.push_back('{ins: Instruction_Code[32*i +: 32], pc: pc_in + 32'(4*i)});
            end
        end
    end

    always @(negedge clk) begin
        bit          ev;
        logic [31:0] eo, ep;
        if (reset) begin
            ev = (mq.size() != 0) && !flush;
            eo = ev ? mq[0].ins : 32'h0;
            ep = ev ? mq[0].pc  : 32'h0;
            check("inst_valid", 32'(inst_valid), 32'(ev));
            check("stall", 32'(stall), 32'(m_occ() == DEPTH));
            check("occupancy", 32'(occupancy), 32'(m_occ()));
            check("inst_out", inst_out, eo);
            check("inst_pc", inst_pc, ep);
            check("inst_pc_plus_4", inst_pc_plus_4, ep + 32'd4);
            if (inst_valid && dec_ready) begin
                $display("issue pc=%h inst=%h occ=%0d", inst_pc, inst_out, occupancy);
                issued_pc.push_back(inst_pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit bv, input logic [31:0] pc, input bit dr, input bit fl);
        bundle_valid     = bv;
        pc_in            = pc;
        Instruction_Code = {32'hC000_0000 | (pc + 32'd4), 32'hC000_0000 | pc};
        dec_ready        = dr;
        flush            = fl;
    endtask

    initial begin
        int b;
        bit will_push;
        reset = 1'b0;
        drive(0, 0, 0, 0);
        #2;
        check("rst_stall", 32'(stall), 0);
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_out", inst_out, 0);
        check("rst_pc", inst_pc, 0);
        check("rst_pc4", inst_pc_plus_4, 32'h4);
        check("rst_occ", 32'(occupancy), 0);
        #11 reset = 1'b1;
        step();

        // Basic flow
        drive(1, 32'h100, 1, 0);
        step();
        drive(0, 0, 1, 0);
        #1;
        check("t1_valid", 32'(inst_valid), 1);
        check("t1_a0", inst_out, 32'hC000_0100);
        check("t1_pc0", inst_pc, 32'h100);
        step();
        #1;
        check("t1_a1", inst_out, 32'hC000_0104);
        check("t1_pc1", inst_pc, 32'h104);
        check("t1_pc4", inst_pc_plus_4, 32'h108);
        step();
        #1;
        check("t1_empty", 32'(inst_valid), 0);

        // Fill until stall; fifth bundle must be refused
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h1000 + 32'(8*k), 0, 0);
            step();
            if (k == 3) begin
                #1;
                check("t2_stall", 32'(stall), 1);
                check("t2_occ", 32'(occupancy), 4);
            end
        end
        drive(0, 0, 1, 0);
        step();
        step();
        #1;
        check("t2_unstall", 32'(stall), 0);
        check("t2_occ3", 32'(occupancy), 3);
        check("t2_head", inst_pc, 32'h1008);
        repeat (6) step();
        #1;
        check("t2_drained", 32'(occupancy), 0);

        // Wrap: 10 bundles through a 4-deep queue with half-rate decode
        issued_pc.delete();
        b = 0;
        for (int cyc = 0; cyc < 200 && issued_pc.size() < 20; cyc++) begin
            drive(b < 10, 32'(8*b), (cyc % 2) == 0, 0);
            will_push = (b < 10) && !stall;
            step();
            if (will_push) b++;
        end
        drive(0, 0, 0, 0);
        check("t3_count", 32'(issued_pc.size()), 20);
        for (int i = 0; i < 20 && i < issued_pc.size(); i++)
            check("t3_order", issued_pc[i], 32'(4*i));

        // Flush with a partially issued head
        drive(1, 32'h300, 0, 0); step();
        drive(1, 32'h308, 0, 0); step();
        drive(1, 32'h310, 0, 0); step();
        drive(0, 0, 1, 0); step();
        drive(1, 32'h990, 1, 1);
        #1;
        check("t4_occ3", 32'(occupancy), 3);
        check("t4_flush_valid", 32'(inst_valid), 0);
        step();
        drive(1, 32'h200, 1, 0);
        #1;
        check("t4_occ0", 32'(occupancy), 0);
        check("t4_valid0", 32'(inst_valid), 0);
        check("t4_stall0", 32'(stall), 0);
        step();
        drive(0, 0, 1, 0);
        #1;
        check("t4_target_valid", 32'(inst_valid), 1);
        check("t4_target_pc", inst_pc, 32'h200);
        step();
        step();
        // Flush while full
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h400 + 32'(8*k), 0, 0);
            step();
        end
        #1;
        check("t4_full", 32'(stall), 1);
        drive(0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0);
        #1;
        check("t4_full_unstall", 32'(stall), 0);
        check("t4_full_occ", 32'(occupancy), 0);

        // Simultaneous push and pop
        drive(1, 32'h500, 0, 0); step();
        drive(1, 32'h508, 0, 0); step();
        drive(0, 0, 1, 0); step();
        drive(1, 32'h510, 1, 0);
        #1;
        check("t5_occ_pre", 32'(occupancy), 2);
        step();
        drive(0, 0, 0, 0);
        #1;
        check("t5_occ_post", 32'(occupancy), 2);
        check("t5_head", inst_pc, 32'h508);
        drive(0, 0, 1, 0);
        repeat (4) step();
        #1;
        check("t5_drained", 32'(occupancy), 0);

        // Asynchronous reset between edges
        drive(1, 32'h600, 0, 0); step();
        drive(1, 32'h608, 0, 0); step();
        drive(1, 32'h610, 0, 0); step();
        drive(0, 0, 0, 0);
        #1;
        check("t6_occ3", 32'(occupancy), 3);
        #1 reset = 1'b0;
        #1;
        check("t6_valid", 32'(inst_valid), 0);
        check("t6_occ", 32'(occupancy), 0);
        check("t6_stall", 32'(stall), 0);
        check("t6_pc4", inst_pc_plus_4, 32'h4);
        #3 reset = 1'b1;
        step();
        drive(1, 32'h0, 1, 0);
        step();
        drive(0, 0, 1, 0);
        #1;
        check("t6_valid_after", 32'(inst_valid), 1);
        check("t6_pc_after", inst_pc, 32'h0);
        check("t6_inst_after", inst_out, 32'hC000_0000);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
